// File: rtl/mmio_mailbox_drain.sv
// Purpose: MMIO mailbox that queues full-word stores to MAILBOX_ADDR and drains them as a {tid, data} valid/ready stream.
// Latency: a push is visible on m_valid one cycle later; a status load returns ld_data one cycle after ld_en.
// Backpressure: stores are never stalled. A push into a full FIFO is dropped, and counted when MAILBOX_DROP_CNT_EN is defined.
module mmio_mailbox_drain #(
    parameter int                    NUM_THREADS  = 16,
    parameter int                    DWIDTH       = 32,
    parameter int                    ADDR_WIDTH   = 10,
    parameter logic [ADDR_WIDTH-1:0] MAILBOX_ADDR = 10'h3FE,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR  = 10'h3FF,
    parameter int                    FIFO_DEPTH   = 16,
    localparam int                   TW           = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_en,
    input  logic [TW-1:0]         st_tid,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [3:0]            st_be,
    input  logic [DWIDTH-1:0]     st_data,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic [DWIDTH-1:0]     ld_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DWIDTH-1:0]     m_data,
    output logic [TW-1:0]         m_tid,
    output logic                  full
);

    // Index width into storage, and pointer width with one extra wrap bit
    // so that full (pointers differ only in the wrap bit) and empty (equal) differ.
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [TW-1:0]     tid;
        logic [DWIDTH-1:0] data;
    } entry_t;

    entry_t          mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   count;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            status_hit;
    logic [15:0]     drop_cnt;
    logic [31:0]     status_word;

    // Occupancy and handshake decode. Fullness comes from the registered pointers,
    // so a push while full is dropped even when a pop completes in the same cycle.
    always_comb begin
        count      = wr_ptr - rd_ptr;
        full       = (count == PW'(FIFO_DEPTH));
        m_valid    = (wr_ptr != rd_ptr);
        push_req   = st_en && (st_addr == MAILBOX_ADDR) && (st_be == 4'b1111);
        push       = push_req && !full;
        pop        = m_valid && m_ready;
        status_hit = ld_en && (ld_addr == STATUS_ADDR);
    end

    // The head entry drives the stream directly and holds until it is popped.
    always_comb begin
        m_data = mem[rd_ptr[AW-1:0]].data;
        m_tid  = mem[rd_ptr[AW-1:0]].tid;
    end

    // Entry storage has no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr[AW-1:0]] <= '{tid: st_tid, data: st_data};
        end
    end

    // The pointers wrap by natural overflow. Reset flushes the FIFO and ignores a same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef MAILBOX_DROP_CNT_EN
    logic drop;

    // A full-word mailbox store that finds the FIFO full counts as a drop.
    always_comb begin
        drop = push_req && full;
    end

    // The drop counter saturates at all-ones and only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    // With the counter compiled out, drops are silent and the status high half reads zero.
    always_comb begin
        drop_cnt = '0;
    end
`endif

    // Status word layout: drop count in the high half, occupancy before this edge in the low half.
    always_comb begin
        status_word = {drop_cnt, 16'(count)};
    end

    // Register the status word on a status load; any other cycle returns zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_data <= '0;
        end else if (status_hit) begin
            ld_data <= DWIDTH'(status_word);
        end else begin
            ld_data <= '0;
        end
    end

endmodule

// File: tb/tb_mmio_mailbox_drain.sv
// Bench for mmio_mailbox_drain: directed scenarios followed by randomized traffic.
// A queue-based reference model checks every output after every clock edge.
// Build with or without MAILBOX_DROP_CNT_EN; the expected drop field follows the same macro.
module tb_mmio_mailbox_drain;

    localparam int          DEPTH = 16;
    localparam logic [9:0]  MBOX  = 10'h3FE;
    localparam logic [9:0]  STAT  = 10'h3FF;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_en;
    logic [3:0]  st_tid;
    logic [9:0]  st_addr;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_tid;
    logic        full;

    int tests = 0;
    int fails = 0;

    // Reference model state: queued {tid, data} words, total drops, and the expected ld_data.
    logic [35:0] mq [$];
    int          drops = 0;
    logic [31:0] exp_ld = '0;

    mmio_mailbox_drain dut (
        .clk     (clk),
        .reset   (reset),
        .st_en   (st_en),
        .st_tid  (st_tid),
        .st_addr (st_addr),
        .st_be   (st_be),
        .st_data (st_data),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_tid   (m_tid),
        .full    (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] drop_field();
`ifdef MAILBOX_DROP_CNT_EN
        return (drops > 65535) ? 16'hFFFF : 16'(drops);
`else
        return 16'h0000;
`endif
    endfunction

    // Advance one clock edge, update the model from the inputs that edge sampled, then check the DUT outputs.
    task automatic cycle();
        bit          push_req;
        bit          pop;
        bit          was_full;
        logic [31:0] nld;
        push_req = st_en && (st_addr == MBOX) && (st_be == 4'hF);
        pop      = (mq.size() != 0) && m_ready;
        was_full = (mq.size() == DEPTH);
        nld      = (ld_en && ld_addr == STAT) ? {drop_field(), 16'(mq.size())} : 32'h0;
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            drops  = 0;
            exp_ld = '0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push_req) begin
                if (was_full) drops++;
                else mq.push_back({st_tid, st_data});
            end
            exp_ld = nld;
        end
        chk("m_valid", 36'(m_valid), 36'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_data", 36'(m_data), 36'(mq[0][31:0]));
            chk("m_tid", 36'(m_tid), 36'(mq[0][35:32]));
        end
        chk("full", 36'(full), 36'(mq.size() == DEPTH));
        chk("ld_data", 36'(ld_data), 36'(exp_ld));
    endtask

    task automatic idle();
        st_en   = 1'b0;
        st_be   = 4'hF;
        st_addr = '0;
        ld_en   = 1'b0;
        ld_addr = '0;
    endtask

    task automatic store(input logic [3:0] tid, input logic [31:0] data, input logic [9:0] addr, input logic [3:0] be);
        st_en   = 1'b1;
        st_tid  = tid;
        st_data = data;
        st_addr = addr;
        st_be   = be;
    endtask

    task automatic status_load();
        ld_en   = 1'b1;
        ld_addr = STAT;
    endtask

    initial begin
        logic [31:0] exp_status;

        idle();
        st_tid  = '0;
        st_data = '0;
        m_ready = 1'b0;
        reset   = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        chk("reset_m_valid", 36'(m_valid), 36'd0);
        chk("reset_full", 36'(full), 36'd0);
        chk("reset_ld_data", 36'(ld_data), 36'd0);

        // Single store becomes visible one cycle later, then drains.
        m_ready = 1'b1;
        store(4'd3, 32'hDEADBEEF, MBOX, 4'hF);
        cycle();
        idle();
        chk("t1_valid", 36'(m_valid), 36'd1);
        chk("t1_data", 36'(m_data), 36'hDEADBEEF);
        chk("t1_tid", 36'(m_tid), 36'd3);
        cycle();
        chk("t1_empty", 36'(m_valid), 36'd0);

        // A partial-word store and a store to a neighbouring address have no effect.
        store(4'd1, 32'h11111111, MBOX, 4'b0011);
        cycle();
        store(4'd2, 32'h22222222, 10'h3FD, 4'hF);
        cycle();
        idle();
        status_load();
        cycle();
        idle();
        cycle();
        chk("t4_status", 36'(ld_data), 36'd0);
        chk("t4_no_valid", 36'(m_valid), 36'd0);

        // Fill all 16 entries, then drain them in order.
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            store(4'(i), 32'(i), MBOX, 4'hF);
            cycle();
        end
        idle();
        chk("t2_full", 36'(full), 36'd1);
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_order", 36'(m_data), 36'(i));
            cycle();
        end
        chk("t2_drained", 36'(m_valid), 36'd0);

        // Refill, then make three stores while full; the third coincides with a pop.
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            store(4'(i), 32'h100 + 32'(i), MBOX, 4'hF);
            cycle();
        end
        store(4'd7, 32'hBAD00001, MBOX, 4'hF);
        cycle();
        store(4'd8, 32'hBAD00002, MBOX, 4'hF);
        cycle();
        m_ready = 1'b1;
        store(4'd9, 32'hBAD00003, MBOX, 4'hF);
        cycle();
        m_ready = 1'b0;
        idle();
        status_load();
        cycle();
        idle();
`ifdef MAILBOX_DROP_CNT_EN
        exp_status = 32'h0003_000F;
`else
        exp_status = 32'h0000_000F;
`endif
        chk("t3_status", 36'(ld_data), 36'(exp_status));
        m_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            chk("t3_survivor", 36'(m_data), 36'h100 + 36'(i));
            cycle();
        end
        chk("t3_drained", 36'(m_valid), 36'd0);

        // Reset in the middle of operation flushes queued words and counters.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            store(4'(i), $urandom, MBOX, 4'hF);
            cycle();
        end
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t5_valid", 36'(m_valid), 36'd0);
        chk("t5_full", 36'(full), 36'd0);
        status_load();
        cycle();
        idle();
        chk("t5_status", 36'(ld_data), 36'd0);

        // Push and pop every cycle: occupancy stays at most one and nothing is dropped.
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            store(4'($urandom_range(0, 15)), $urandom, MBOX, 4'hF);
            status_load();
            cycle();
            if (i > 0) chk("t6_occ_le1", 36'(ld_data[15:0] <= 16'd1), 36'd1);
        end
        idle();
        cycle();
        cycle();
        chk("t6_no_drops", 36'(drop_field()), 36'd0);

        // Randomized traffic across mailbox, status and neighbouring addresses.
        for (int i = 0; i < 600; i++) begin
            logic [9:0] addrs [3];
            addrs[0] = MBOX;
            addrs[1] = STAT;
            addrs[2] = 10'h3FD;
            st_en   = ($urandom_range(0, 3) != 0);
            st_tid  = 4'($urandom_range(0, 15));
            st_data = $urandom;
            st_addr = ($urandom_range(0, 4) != 0) ? MBOX : addrs[$urandom_range(0, 2)];
            st_be   = ($urandom_range(0, 7) != 0) ? 4'hF : 4'($urandom_range(0, 14));
            ld_en   = ($urandom_range(0, 1) != 0);
            ld_addr = ($urandom_range(0, 3) != 0) ? STAT : addrs[$urandom_range(0, 2)];
            m_ready = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 127) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
